// File: rtl/dmem_param.sv
// Parameterised data memory with byte-lane writes, a 1-cycle registered read,
// a preload port for boot loaders, and a self-clearing sequence after reset.
//
// Handshake: a preload beat transfers on a rising edge where ld_valid and
// ld_ready are both 1. The requester must hold ld_valid, ld_addr and ld_data
// stable until that edge. ld_ready is combinational. It is 1 only in RUN
// while the CPU is not writing.
module dmem_param #(
    parameter int DW    = 16,
    parameter int AW    = 8,
    parameter int DEPTH = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_dataout,
    input  logic [DW/8-1:0]   d_be,
    output logic [DW-1:0]     d_datain,
    output logic              busy,
    input  logic              ld_valid,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DW-1:0]     ld_data,
    output logic              ld_ready,
    output logic              err
);

    localparam int              NB       = DW / 8;
    localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // This is one bit wider than an address, so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0]     DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic [DW-1:0]    d_datain_q, d_datain_d;
    logic             err_q, err_d;

    logic [DW-1:0]    mem_q [DEPTH];

    logic             cpu_in_range;
    logic             ld_in_range;
    logic             cpu_access;
    logic             ld_accept;
    logic [IW-1:0]    cpu_idx;
    logic [IW-1:0]    ld_idx;

    // This is the single memory write port. Clear, CPU write and preload never
    // need it in the same cycle.
    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic [DW-1:0]    wr_data;
    logic [NB-1:0]    wr_be;

    assign busy     = (state_q == ST_CLEAR);
    assign ld_ready = (state_q == ST_RUN) && !d_we;
    assign d_datain = d_datain_q;
    assign err      = err_q;

    // Decode the requests. A write with no byte lanes enabled does not count as an access.
    always_comb begin
        cpu_in_range = ({1'b0, d_addr} < DEPTH_W);
        ld_in_range  = ({1'b0, ld_addr} < DEPTH_W);
        cpu_access   = (state_q == ST_RUN) && (!d_we || (|d_be));
        ld_accept    = ld_valid && ld_ready;
        cpu_idx      = d_addr[IW-1:0];
        ld_idx       = ld_addr[IW-1:0];
    end

    // Compute the next state, the clear pointer, the read register, err and the write port.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        d_datain_d = d_datain_q;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_data    = '0;
        wr_be      = '0;

        case (state_q)
            ST_CLEAR: begin
                wr_en      = 1'b1;
                wr_idx     = clr_ptr_q[IW-1:0];
                wr_data    = '0;
                wr_be      = '1;
                d_datain_d = '0;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end

            ST_RUN: begin
                err_d = (cpu_access && !cpu_in_range) ||
                        (ld_accept && !ld_in_range);
                if (d_we) begin
                    // The CPU write owns the port. The preload is refused through ld_ready.
                    if (cpu_in_range && (|d_be)) begin
                        wr_en   = 1'b1;
                        wr_idx  = cpu_idx;
                        wr_data = d_dataout;
                        wr_be   = d_be;
                    end
                end else begin
                    if (ld_accept && ld_in_range) begin
                        wr_en   = 1'b1;
                        wr_idx  = ld_idx;
                        wr_data = ld_data;
                        wr_be   = '1;
                    end
                    // A read that hits the address being preloaded gets the new data.
                    if (!cpu_in_range) begin
                        d_datain_d = '0;
                    end else if (ld_accept && ld_in_range && (ld_addr == d_addr)) begin
                        d_datain_d = ld_data;
                    end else begin
                        d_datain_d = mem_q[cpu_idx];
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Register the state. A synchronous active-low reset restarts the clear from word 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            d_datain_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            d_datain_q <= d_datain_d;
            err_q      <= err_d;
        end
    end

    // Write the storage array one byte lane at a time. No writes happen while reset is held.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_param.sv
// Self-checking bench for dmem_param with the default sizes (DW=16, AW=8, DEPTH=64).
module tb_dmem_param;

    logic        clock;
    logic        reset;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic [1:0]  d_be;
    logic [15:0] d_datain;
    logic        busy;
    logic        ld_valid;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        err;

    int          total;
    int          bad;
    logic [15:0] exp_q [$];
    logic [15:0] model_mem [64];
    logic [15:0] last_dout;

    dmem_param #(.DW(16), .AW(8), .DEPTH(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_be      (d_be),
        .d_datain  (d_datain),
        .busy      (busy),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .err       (err)
    );

    // Generate the clock and a watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Run one RUN-mode cycle and update the reference model from the spec rules.
    task automatic do_cycle(input logic we, input logic [7:0] addr, input logic [15:0] dout,
                            input logic [1:0] be, input logic ldv, input logic [7:0] la,
                            input logic [15:0] ld);
        logic        ld_acc;
        logic        cpu_acc;
        logic        e_err;
        logic [15:0] e_rd;
        d_we      = we;
        d_addr    = addr;
        d_dataout = dout;
        d_be      = be;
        ld_valid  = ldv;
        ld_addr   = la;
        ld_data   = ld;
        #1;
        check("ld_ready", {31'd0, ld_ready}, {31'd0, !we});
        ld_acc  = ldv && !we;
        cpu_acc = !we || (be != 2'b00);
        e_err   = (cpu_acc && addr >= 8'd64) || (ld_acc && la >= 8'd64);
        if (!we) begin
            if (addr >= 8'd64)              e_rd = 16'h0000;
            else if (ld_acc && la == addr)  e_rd = ld;
            else                            e_rd = model_mem[addr[5:0]];
            exp_q.push_back(e_rd);
        end
        if (we && addr < 8'd64) begin
            for (int i = 0; i < 2; i++) begin
                if (be[i]) model_mem[addr[5:0]][i*8 +: 8] = dout[i*8 +: 8];
            end
        end
        if (ld_acc && la < 8'd64) model_mem[la[5:0]] = ld;
        @(posedge clock);
        #1;
        if (!we) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                last_dout = exp_q.pop_front();
                check("rd_data", {16'd0, d_datain}, {16'd0, last_dout});
            end
        end else begin
            check("wr_hold", {16'd0, d_datain}, {16'd0, last_dout});
        end
        check("err", {31'd0, err}, {31'd0, e_err});
        d_we     = 1'b0;
        ld_valid = 1'b0;
    endtask

    // Hold reset low, release it, and measure the clear sequence while hammering the ports.
    task automatic reset_and_clear(input int pre);
        int n;
        reset = 1'b0;
        repeat (pre) begin
            d_we = 1'b0; ld_valid = 1'b1; ld_addr = 8'd1; ld_data = 16'hbeef;
            @(posedge clock);
            #1;
            check("rst_busy", {31'd0, busy}, 32'd1);
            check("rst_dout", {16'd0, d_datain}, 32'd0);
            check("rst_ldrdy", {31'd0, ld_ready}, 32'd0);
            check("rst_err", {31'd0, err}, 32'd0);
        end
        reset = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            d_we      = 1'($urandom_range(0, 1));
            d_addr    = 8'($urandom_range(0, 63));
            d_dataout = 16'hffff;
            d_be      = 2'b11;
            ld_valid  = 1'b1;
            ld_addr   = 8'($urandom_range(0, 63));
            ld_data   = 16'hffff;
            #1;
            check("clr_ldrdy", {31'd0, ld_ready}, 32'd0);
            @(posedge clock);
            #1;
            n++;
            check("clr_dout", {16'd0, d_datain}, 32'd0);
            check("clr_err", {31'd0, err}, 32'd0);
        end
        check("clr_len", n, 32'd64);
        d_we = 1'b0; ld_valid = 1'b0;
        for (int i = 0; i < 64; i++) model_mem[i] = 16'h0000;
        last_dout = 16'h0000;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; d_we = 1'b0; d_addr = '0; d_dataout = '0; d_be = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        last_dout = '0;
        for (int i = 0; i < 64; i++) model_mem[i] = 16'h0000;

        reset_and_clear(3);
        for (int a = 0; a < 64; a++) do_cycle(1'b0, 8'(a), 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);

        // Preload three words, then check that a CPU write refuses a preload.
        do_cycle(1'b0, 8'd10, 16'h0, 2'b00, 1'b1, 8'd0, 16'hfffd);
        do_cycle(1'b0, 8'd10, 16'h0, 2'b00, 1'b1, 8'd1, 16'h0004);
        do_cycle(1'b0, 8'd10, 16'h0, 2'b00, 1'b1, 8'd3, 16'hc369);
        do_cycle(1'b1, 8'd2, 16'h1111, 2'b11, 1'b1, 8'd7, 16'h7777);
        do_cycle(1'b0, 8'd7, 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);
        check("no_ld_on_wr", {16'd0, d_datain}, 32'h0000);
        do_cycle(1'b0, 8'd3, 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);
        check("rd3", {16'd0, d_datain}, 32'hc369);

        // Byte-lane writes.
        do_cycle(1'b0, 8'd10, 16'h0, 2'b00, 1'b1, 8'd4, 16'h69c3);
        do_cycle(1'b1, 8'd4, 16'hab12, 2'b01, 1'b0, 8'h0, 16'h0);
        do_cycle(1'b0, 8'd4, 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);
        check("be01", {16'd0, d_datain}, 32'h6912);
        do_cycle(1'b1, 8'd4, 16'hab12, 2'b10, 1'b0, 8'h0, 16'h0);
        do_cycle(1'b0, 8'd4, 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);
        check("be10", {16'd0, d_datain}, 32'hab12);
        do_cycle(1'b1, 8'd4, 16'h0000, 2'b00, 1'b0, 8'h0, 16'h0);
        do_cycle(1'b1, 8'd64, 16'h0000, 2'b00, 1'b0, 8'h0, 16'h0);
        do_cycle(1'b0, 8'd4, 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);
        check("be00_noop", {16'd0, d_datain}, 32'hab12);

        // A same-cycle read and preload to one address returns the new data.
        do_cycle(1'b0, 8'd5, 16'h0, 2'b00, 1'b1, 8'd5, 16'h0041);
        check("write_first", {16'd0, d_datain}, 32'h0041);

        // Out-of-range accesses.
        do_cycle(1'b1, 8'd64, 16'h5555, 2'b11, 1'b0, 8'h0, 16'h0);
        check("oor_wr_err", {31'd0, err}, 32'd1);
        do_cycle(1'b0, 8'd64, 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);
        check("oor_rd_zero", {16'd0, d_datain}, 32'h0000);
        do_cycle(1'b0, 8'd0, 16'h0, 2'b00, 1'b1, 8'd64, 16'h9999);
        check("mem0_kept", {16'd0, d_datain}, 32'hfffd);
        do_cycle(1'b0, 8'd255, 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);
        do_cycle(1'b0, 8'd63, 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);
        check("addr63_ok", {31'd0, err}, 32'd0);

        // Random mixed traffic.
        for (int k = 0; k < 300; k++) begin
            do_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 70)),
                     16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 8'($urandom_range(0, 70)),
                     16'($urandom_range(0, 65535)));
        end

        // Reset in the middle of a clear, then verify a fresh full clear.
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            check("mid_busy", {31'd0, busy}, 32'd1);
            check("mid_dout", {16'd0, d_datain}, 32'd0);
        end
        reset_and_clear(2);
        for (int a = 0; a < 64; a++) do_cycle(1'b0, 8'(a), 16'h0, 2'b00, 1'b0, 8'h0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
